// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_ctrl_pkg: shared core constants, state encoding, hazards  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pipeline_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] c_st_run        = 2'd0;
  localparam logic [1:0] c_st_mem_wait   = 2'd1;
  localparam logic [1:0] c_st_redir_wait = 2'd2;

  // addi x0, x0, 0 is the canonical NOP loaded on flush or bubble
  localparam logic [31:0] c_nop_instr = 32'h0000_0013;
  localparam logic [4:0]  c_reg_zero  = 5'd0;

  function automatic logic load_use_hazard(
    input logic       mem_rd,
    input logic       reg_we,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       rs1_used,
    input logic       rs2_used
  );
    return mem_rd & reg_we & (rd != c_reg_zero) &
           ((rs1_used & (rs1 == rd)) | (rs2_used & (rs2 == rd)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_perf_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | perf_counter: wrapping event counter with async active-low clear   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_ctrl: stall/flush/bubble control and perf counters        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_addr_id,
  input  logic [4:0]           rs2_addr_id,
  input  logic                 rs1_used_id,
  input  logic                 rs2_used_id,
  input  logic [4:0]           rd_addr_ex,
  input  logic                 reg_we_ex,
  input  logic                 mem_rd_ex,
  input  logic                 redirect_ex,
  input  logic                 dmem_req_mem,
  input  logic                 dmem_ready,
  input  logic                 imem_ready,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 flush_id,
  output logic                 bubble_ex,
  output logic                 bubble_wb,
  output logic                 redirect_sel,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  state_t state_q;
  state_t state_d;
  logic   w_mem_stall;
  logic   w_load_use;
  logic   w_stall_any;
  logic   w_redirect_accept;

  assign w_mem_stall = dmem_req_mem & ~dmem_ready;
  assign w_load_use  = load_use_hazard(mem_rd_ex, reg_we_ex, rd_addr_ex,
                                       rs1_addr_id, rs2_addr_id,
                                       rs1_used_id, rs2_used_id);

  always_comb begin
    state_d           = state_q;
    stall_if          = 1'b0;
    stall_id          = 1'b0;
    stall_ex          = 1'b0;
    flush_id          = 1'b0;
    bubble_ex         = 1'b0;
    bubble_wb         = 1'b0;
    redirect_sel      = 1'b0;
    w_redirect_accept = 1'b0;
    if (rst) begin
      if (w_mem_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        bubble_wb = 1'b1;
        state_d   = c_st_mem_wait;
      end else if (state_q == c_st_redir_wait) begin
        // Keep the PC on the redirect target until the fetch lands
        redirect_sel = 1'b1;
        flush_id     = 1'b1;
        if (imem_ready) begin
          state_d = c_st_run;
        end
      end else begin
        // Leaving MEM_WAIT is evaluated exactly like RUN
        state_d = c_st_run;
        if (redirect_ex) begin
          redirect_sel      = 1'b1;
          flush_id          = 1'b1;
          bubble_ex         = 1'b1;
          w_redirect_accept = 1'b1;
          if (!imem_ready) begin
            state_d = c_st_redir_wait;
          end
        end else begin
          if (w_load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
          if (!imem_ready) begin
            stall_if = 1'b1;
            flush_id = ~w_load_use;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_st_run;
    end else begin
      state_q <= state_d;
    end
  end

  assign w_stall_any = stall_if | stall_id | stall_ex;

  perf_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_stall_any),
    .o_cnt (stall_cnt)
  );

  perf_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_redirect_accept),
    .o_cnt (flush_cnt)
  );

endmodule
`default_nettype wire
